// File: rtl/scan_sequencer.sv
// Scan sequencer for a 2-to-4 line decoder: steps through enabled lines in ascending order,
// holding each active for a programmable dwell with optional blanking between lines.
module scan_sequencer #(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [3:0]         blank,
  input  logic [3:0]         mask,
  output logic               a,
  output logic               b,
  output logic               en,
  output logic               wrap,
  output logic               busy
);

  localparam int unsigned CntW = (DWELL_W > 4) ? DWELL_W : 4;

  typedef enum logic [1:0] {StIdle, StActive, StBlank} state_e;

  state_e          state_q;
  logic [1:0]      addr_q;
  logic [CntW-1:0] cnt_q;
  logic            en_q;
  logic            wrap_q;
  logic            busy_q;

  logic [1:0]      low_idx;
  logic [1:0]      nxt_idx;
  logic [1:0]      cand;
  logic            found;
  logic            nxt_wrap;
  logic [CntW-1:0] dwell_ld;
  logic [CntW-1:0] blank_ld;

  always_comb begin
    low_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i]) low_idx = 2'(i);
    end
    // Search upward from current+1; the fourth candidate is the current line itself.
    nxt_idx = addr_q;
    cand    = addr_q;
    found   = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand = addr_q + 2'(i);
      if (!found && mask[cand]) begin
        nxt_idx = cand;
        found   = 1'b1;
      end
    end
    nxt_wrap = (nxt_idx <= addr_q);
    dwell_ld = (dwell == '0) ? '0 : CntW'(dwell - DWELL_W'(1));
    blank_ld = CntW'(blank - 4'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= 2'd0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      wrap_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          en_q   <= 1'b0;
          busy_q <= 1'b0;
          if (run && (mask != 4'd0)) begin
            state_q <= StActive;
            addr_q  <= low_idx;
            cnt_q   <= dwell_ld;
            en_q    <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        StActive: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CntW'(1);
          end else if (!run || (mask == 4'd0)) begin
            state_q <= StIdle;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
          end else if (blank == 4'd0) begin
            addr_q <= nxt_idx;
            wrap_q <= nxt_wrap;
            cnt_q  <= dwell_ld;
          end else begin
            state_q <= StBlank;
            cnt_q   <= blank_ld;
            en_q    <= 1'b0;
          end
        end
        StBlank: begin
          if (!run || ((cnt_q == '0) && (mask == 4'd0))) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CntW'(1);
          end else begin
            state_q <= StActive;
            addr_q  <= nxt_idx;
            wrap_q  <= nxt_wrap;
            cnt_q   <= dwell_ld;
            en_q    <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          en_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign a    = addr_q[1];
  assign b    = addr_q[0];
  assign en   = en_q;
  assign wrap = wrap_q;
  assign busy = busy_q;

endmodule
